serdes_64b66b_rx_descrambler: RTL and testbench

Receive-side counterpart of the 64B/66B TX scrambler for the 25G SerDes PCS. Takes gearbox-aligned 66-bit blocks (64-bit payload plus 2-bit sync header, with a 0–32 sequence counter), removes the x^58+x^39+1 self-synchronising scrambling, and runs a sync-header block-lock state machine. The state machine drives gearbox bit-slip requests. The block sits between the RX gearbox and the 64B/66B decoder.

---
 rtl/serdes_64b66b_rx_descrambler_pkg.sv | 32 +++
 rtl/serdes_64b66b_rx_descrambler_if.sv | 26 ++
 rtl/serdes_64b66b_rx_block_lock.sv | 121 ++++++++++++
 rtl/serdes_64b66b_rx_descrambler.sv | 101 ++++++++++
 tb/tb_serdes_64b66b_rx_descrambler.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/serdes_64b66b_rx_descrambler_pkg.sv
// Shared types and constants for the 64B/66B RX descrambler and block-lock logic.
package serdes_64b66b_rx_descrambler_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned SEQ_W  = 6;
   localparam int unsigned HDR_W  = 2;
   localparam int unsigned SCR_W  = 58;

   // x^58 + x^39 + 1 taps
   localparam int unsigned TAP_A = 39;
   localparam int unsigned TAP_B = 58;

   localparam logic [HDR_W-1:0] SH_DATA = 2'b01;
   localparam logic [HDR_W-1:0] SH_CTRL = 2'b10;

   typedef enum logic [1:0] {
      HUNT      = 2'd0,
      SLIP_WAIT = 2'd1,
      LOCKED    = 2'd2
   } lock_state_e;

   typedef struct packed {
      logic [SEQ_W-1:0]  seq;
      logic [HDR_W-1:0]  header;
      logic [DATA_W-1:0] data;
   } rx_blk_t;

   function automatic logic hdr_valid(input logic [HDR_W-1:0] h);
      return (h == SH_DATA) || (h == SH_CTRL);
   endfunction

endpackage

// File: rtl/serdes_64b66b_rx_descrambler_if.sv
// Block bus between the RX gearbox, the descrambler and the 64B/66B decoder.
interface serdes_64b66b_rx_descrambler_if
   import serdes_64b66b_rx_descrambler_pkg::*;
();
   logic [DATA_W-1:0] rx_data;
   logic [SEQ_W-1:0]  rx_seq;
   logic [HDR_W-1:0]  rx_header;
   logic [DATA_W-1:0] rx_descramble_data;
   logic [SEQ_W-1:0]  rx_descramble_seq;
   logic [HDR_W-1:0]  rx_descramble_header;
   logic              rx_block_lock;
   logic              rx_slip;
   logic              rx_hdr_err;

   modport master (
      output rx_data, rx_seq, rx_header,
      input  rx_descramble_data, rx_descramble_seq, rx_descramble_header,
      input  rx_block_lock, rx_slip, rx_hdr_err
   );

   modport slave (
      input  rx_data, rx_seq, rx_header,
      output rx_descramble_data, rx_descramble_seq, rx_descramble_header,
      output rx_block_lock, rx_slip, rx_hdr_err
   );
endinterface

// File: rtl/serdes_64b66b_rx_block_lock.sv
// Sync-header block-lock FSM with slip/header-error pulses.
// Compiled only when SERDES_RX_BLOCK_LOCK_EN is defined.
`ifdef SERDES_RX_BLOCK_LOCK_EN
module serdes_64b66b_rx_block_lock
   import serdes_64b66b_rx_descrambler_pkg::*;
#(
   parameter int unsigned C_LOCK_CNT  = 64,
   parameter int unsigned C_INVLD_MAX = 16,
   parameter int unsigned C_SLIP_WAIT = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [HDR_W-1:0] header,
   output logic             block_lock,
   output logic             slip,
   output logic             hdr_err
);
   localparam int unsigned SH_W   = 7;
   localparam int unsigned WIN_W  = 6;
   localparam int unsigned INV_W  = 5;
   localparam int unsigned WAIT_W = 6;

   lock_state_e        state_q, state_d;
   logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [INV_W-1:0]   invld_cnt_q, invld_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               lock_d, slip_d, hdr_err_d;
   logic               hdr_ok;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         sh_cnt_q    <= '0;
         win_cnt_q   <= '0;
         invld_cnt_q <= '0;
         wait_cnt_q  <= '0;
         block_lock  <= 1'b0;
         slip        <= 1'b0;
         hdr_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_cnt_q    <= sh_cnt_d;
         win_cnt_q   <= win_cnt_d;
         invld_cnt_q <= invld_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         block_lock  <= lock_d;
         slip        <= slip_d;
         hdr_err     <= hdr_err_d;
      end
   end

   // Headers are only tested on valid cycles in HUNT and LOCKED.
   always_comb begin
      state_d     = state_q;
      sh_cnt_d    = sh_cnt_q;
      win_cnt_d   = win_cnt_q;
      invld_cnt_d = invld_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      slip_d      = 1'b0;
      hdr_err_d   = 1'b0;
      hdr_ok      = hdr_valid(header);

      unique case (state_q)
         HUNT: begin
            if (sh_cnt_q == SH_W'(C_LOCK_CNT)) begin
               state_d     = LOCKED;
               sh_cnt_d    = '0;
               win_cnt_d   = '0;
               invld_cnt_d = '0;
            end else if (valid) begin
               if (hdr_ok) begin
                  sh_cnt_d = sh_cnt_q + SH_W'(1);
               end else begin
                  hdr_err_d  = 1'b1;
                  slip_d     = 1'b1;
                  sh_cnt_d   = '0;
                  wait_cnt_d = '0;
                  state_d    = SLIP_WAIT;
               end
            end
         end
         SLIP_WAIT: begin
            if (valid) begin
               if (wait_cnt_q == WAIT_W'(C_SLIP_WAIT - 1)) begin
                  wait_cnt_d = '0;
                  sh_cnt_d   = '0;
                  state_d    = HUNT;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
         end
         LOCKED: begin
            if (valid) begin
               win_cnt_d = win_cnt_q + WIN_W'(1);
               if (!hdr_ok) begin
                  hdr_err_d   = 1'b1;
                  invld_cnt_d = invld_cnt_q + INV_W'(1);
               end
               // Loss of lock wins over a window wrap in the same cycle.
               if (invld_cnt_d == INV_W'(C_INVLD_MAX)) begin
                  slip_d      = 1'b1;
                  state_d     = SLIP_WAIT;
                  win_cnt_d   = '0;
                  invld_cnt_d = '0;
                  wait_cnt_d  = '0;
               end else if (win_cnt_q == '1) begin
                  invld_cnt_d = '0;
               end
            end
         end
         default: state_d = HUNT;
      endcase

      lock_d = (state_d == LOCKED);
   end

endmodule
`endif

// File: rtl/serdes_64b66b_rx_descrambler.sv
// 64B/66B RX self-synchronising descrambler (x^58+x^39+1) with optional block lock.
// Block-lock FSM is built only when SERDES_RX_BLOCK_LOCK_EN is defined.
module serdes_64b66b_rx_descrambler
   import serdes_64b66b_rx_descrambler_pkg::*;
#(
   parameter int unsigned C_RX_DATA_WIDTH = 64
`ifdef SERDES_RX_BLOCK_LOCK_EN
   ,
   parameter int unsigned C_LOCK_CNT  = 64,
   parameter int unsigned C_INVLD_MAX = 16,
   parameter int unsigned C_SLIP_WAIT = 32
`endif
) (
   input  logic                           I_pcs_rx_clk,
   input  logic                           I_pcs_rx_rst_n,
   serdes_64b66b_rx_descrambler_if.slave  rx
);
   localparam int unsigned HALF_W = C_RX_DATA_WIDTH / 2;

   typedef struct packed {
      logic [HALF_W-1:0] d;
      logic [SCR_W-1:0]  s;
   } half_t;

   // x = {received bits, last 58 received bits}; x[SCR_W+i] is received bit i.
   function automatic half_t descr_half(input logic [HALF_W-1:0] r,
                                        input logic [SCR_W-1:0]  s);
      logic [SCR_W+HALF_W-1:0] x;
      half_t                   o;
      x = {r, s};
      o = '0;
      for (int i = 0; i < int'(HALF_W); i++) begin
         o.d[i] = x[SCR_W+i] ^ x[SCR_W-TAP_A+i] ^ x[SCR_W-TAP_B+i];
      end
      o.s = x[SCR_W+HALF_W-1:HALF_W];
      return o;
   endfunction

   logic [SCR_W-1:0] scr_q;
   rx_blk_t          out_q;
   half_t            lo_c, hi_c;
   logic             valid;
   logic             block_lock, slip, hdr_err;

   assign valid = ~rx.rx_seq[SEQ_W-1];

   // Low half first, its updated state feeds the high half in the same cycle.
   always_comb begin
      lo_c = descr_half(rx.rx_data[HALF_W-1:0], scr_q);
      hi_c = descr_half(rx.rx_data[C_RX_DATA_WIDTH-1:HALF_W], lo_c.s);
   end

   always_ff @(posedge I_pcs_rx_clk) begin
      if (!I_pcs_rx_rst_n) begin
         scr_q <= '0;
         out_q <= '0;
      end else begin
         out_q.seq    <= rx.rx_seq;
         out_q.header <= rx.rx_header;
         if (valid) begin
            scr_q      <= hi_c.s;
            out_q.data <= {hi_c.d, lo_c.d};
         end
      end
   end

`ifdef SERDES_RX_BLOCK_LOCK_EN
   serdes_64b66b_rx_block_lock #(
      .C_LOCK_CNT  (C_LOCK_CNT),
      .C_INVLD_MAX (C_INVLD_MAX),
      .C_SLIP_WAIT (C_SLIP_WAIT)
   ) u_block_lock (
      .clk        (I_pcs_rx_clk),
      .rst_n      (I_pcs_rx_rst_n),
      .valid      (valid),
      .header     (rx.rx_header),
      .block_lock (block_lock),
      .slip       (slip),
      .hdr_err    (hdr_err)
   );
`else
   // Without lock detection the block reports lock one cycle after reset release.
   always_ff @(posedge I_pcs_rx_clk) begin
      if (!I_pcs_rx_rst_n) begin
         block_lock <= 1'b0;
      end else begin
         block_lock <= 1'b1;
      end
   end
   assign slip    = 1'b0;
   assign hdr_err = 1'b0;
`endif

   assign rx.rx_descramble_data   = out_q.data;
   assign rx.rx_descramble_seq    = out_q.seq;
   assign rx.rx_descramble_header = out_q.header;
   assign rx.rx_block_lock        = block_lock;
   assign rx.rx_slip              = slip;
   assign rx.rx_hdr_err           = hdr_err;

endmodule

// File: tb/tb_serdes_64b66b_rx_descrambler.sv
// Scoreboard bench: bit-serial TX scrambler model feeding the RX descrambler, plus lock/slip scenarios.
module tb_serdes_64b66b_rx_descrambler;

`ifdef SERDES_RX_BLOCK_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic [5:0]  seq;
      logic [1:0]  hdr;
      logic        err;
      logic        slip;
      logic        lock;
   } exp_t;

   logic        clk;
   logic        rst_n;
   exp_t        sb[$];
   logic [57:0] tx_st;
   logic [63:0] payload;
   logic [63:0] last_data;
   logic [5:0]  seq_ctr;
   int          n_checks;
   int          n_errors;
   int          step_no;

   serdes_64b66b_rx_descrambler_if bus ();

   serdes_64b66b_rx_descrambler dut (
      .I_pcs_rx_clk   (clk),
      .I_pcs_rx_rst_n (rst_n),
      .rx             (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL step %0d %s: got %h expected %h", step_no, tag, act, exp);
      end
   endtask

   // Bit-serial reference: s[n] = p[n] ^ s[n-39] ^ s[n-58]; tx_st[k] = s[n-1-k].
   task automatic scramble(input logic [63:0] p, output logic [63:0] s);
      logic b;
      s = '0;
      for (int i = 0; i < 64; i++) begin
         b     = p[i] ^ tx_st[38] ^ tx_st[57];
         s[i]  = b;
         tx_st = {tx_st[56:0], b};
      end
   endtask

   // One cycle: drive inputs, queue the expected outputs, compare after the edge.
   task automatic drive(input bit rst, input bit pause, input logic [1:0] hdr,
                        input bit e_err, input bit e_slip, input bit e_lock);
      exp_t        e;
      exp_t        got;
      logic [63:0] scr;
      e = '0;
      if (rst) begin
         rst_n         = 1'b0;
         bus.rx_data   = 64'h0123_4567_89ab_cdef;
         bus.rx_seq    = 6'd0;
         bus.rx_header = 2'b01;
         tx_st         = '0;
         last_data     = '0;
         seq_ctr       = '0;
      end else begin
         rst_n         = 1'b1;
         bus.rx_header = hdr;
         if (pause) begin
            bus.rx_seq  = 6'd32;
            bus.rx_data = 64'hdead_beef_cafe_f00d;
            e.data      = last_data;
         end else begin
            scramble(payload, scr);
            bus.rx_data = scr;
            bus.rx_seq  = seq_ctr;
            seq_ctr     = (seq_ctr == 6'd31) ? 6'd0 : seq_ctr + 6'd1;
            e.data      = payload;
            last_data   = payload;
            payload     = payload + 64'd1;
         end
         e.seq  = bus.rx_seq;
         e.hdr  = hdr;
         e.err  = LOCK_EN ? e_err  : 1'b0;
         e.slip = LOCK_EN ? e_slip : 1'b0;
         e.lock = LOCK_EN ? e_lock : 1'b1;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      step_no++;
      got = sb.pop_front();
      check("data",   bus.rx_descramble_data,          got.data);
      check("seq",    64'(bus.rx_descramble_seq),      64'(got.seq));
      check("header", 64'(bus.rx_descramble_header),   64'(got.hdr));
      check("hdr_err", 64'(bus.rx_hdr_err),            64'(got.err));
      check("slip",   64'(bus.rx_slip),                64'(got.slip));
      check("lock",   64'(bus.rx_block_lock),          64'(got.lock));
   endtask

   initial begin
      logic [1:0] h;
      n_checks      = 0;
      n_errors      = 0;
      step_no       = 0;
      payload       = 64'h0000_0000_0000_0001;
      last_data     = '0;
      seq_ctr       = '0;
      tx_st         = '0;
      rst_n         = 1'b0;
      bus.rx_data   = '0;
      bus.rx_seq    = '0;
      bus.rx_header = '0;

      drive(1, 0, 2'b00, 0, 0, 0);
      drive(1, 0, 2'b00, 0, 0, 0);

      // Loopback of 200 blocks with one pause; lock after the 64th header.
      for (int j = 1; j <= 200; j++) begin
         h = (j % 3 == 0) ? 2'b10 : 2'b01;
         drive(0, 0, h, 0, 0, j >= 65);
         if (j == 100) drive(0, 1, 2'b01, 0, 0, 1);
      end

      // Mid-run reset while locked, then a HUNT slip.
      drive(1, 0, 2'b01, 0, 0, 0);
      for (int j = 1; j <= 10; j++) drive(0, 0, 2'b01, 0, 0, 0);
      drive(0, 0, 2'b11, 1, 1, 0);
      for (int j = 1; j <= 32; j++) drive(0, 0, (j == 32) ? 2'b00 : 2'b01, 0, 0, 0);
      for (int j = 1; j <= 65; j++) drive(0, 0, 2'b01, 0, 0, j == 65);

      // Window of 15 bad headers keeps lock.
      for (int p = 1; p <= 64; p++) begin
         if (p % 4 == 0 && p <= 60) drive(0, 0, (p % 8 == 0) ? 2'b00 : 2'b11, 1, 0, 1);
         else drive(0, 0, 2'b01, 0, 0, 1);
      end
      // Next window: the 16th bad header drops lock.
      for (int p = 1; p <= 16; p++) begin
         drive(0, 0, (p % 2 == 0) ? 2'b00 : 2'b11, 1, p == 16, p != 16);
      end
      for (int j = 1; j <= 5; j++) drive(0, 0, 2'b00, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
